// File: rtl/plat_land_scheduler_pkg.sv
// Shared constants for the landing scheduler: platform table, sweep sizing and FSM states.
package plat_pkg;

    localparam int NUM_PLAT  = 3;
    localparam int NUM_PAIRS = 2 * NUM_PLAT;
    localparam int IDX_W     = $clog2(NUM_PAIRS);
    localparam int PIDX_W    = $clog2(NUM_PLAT);

    // Element i of each packed array describes platform i; platform 0 is the main stage.
    localparam logic [NUM_PLAT-1:0][9:0] PLAT_X = {10'd420, 10'd115, 10'd100};
    localparam logic [NUM_PLAT-1:0][9:0] PLAT_Y = {10'd215, 10'd215, 10'd400};
    localparam logic [NUM_PLAT-1:0][9:0] PLAT_W = {10'd105, 10'd105, 10'd440};
    localparam logic [NUM_PLAT-1:0]      PLAT_PASS = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/plat_land_scheduler_hit_check.sv
// Combinational landing test of one player hitbox against one platform top edge.
module plat_hit_check #(
    parameter int WIDTH  = 23,
    parameter int HEIGHT = 30
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] next_y,
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic [9:0] pw,
    output logic       hit
);

    localparam logic [10:0] W2 = 11'(2 * WIDTH);
    localparam logic [10:0] H2 = 11'(2 * HEIGHT);

    logic [10:0] x_e, y_e, ny_e, px_e, py_e, pw_e;

    // One extra bit keeps every sum exact; all bounds are inclusive.
    assign x_e  = {1'b0, x};
    assign y_e  = {1'b0, y};
    assign ny_e = {1'b0, next_y};
    assign px_e = {1'b0, px};
    assign py_e = {1'b0, py};
    assign pw_e = {1'b0, pw};

    assign hit = (y_e + H2 <= py_e) && (ny_e + H2 >= py_e) &&
                 (x_e + W2 >= px_e) && (x_e <= px_e + pw_e);

endmodule

// File: rtl/plat_land_scheduler.sv
// Per-frame landing scheduler: one shared comparator swept over every (player, platform) pair.
// Optional macro PLAT_DROP_THROUGH_EN lets a held drop request skip passable platforms.
//
// state | meaning
// IDLE  | waiting for frame_tick, outputs hold
// SCAN  | one (player, platform) pair tested per clock
// DONE  | one-cycle done pulse, fresh results visible
module plat_land_scheduler #(
    parameter int WIDTH  = 23,
    parameter int HEIGHT = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [9:0] p0_x,
    input  logic [9:0] p0_y,
    input  logic [9:0] p0_next_y,
    input  logic [9:0] p1_x,
    input  logic [9:0] p1_y,
    input  logic [9:0] p1_next_y,
    input  logic       p0_drop,
    input  logic       p1_drop,
    output logic       p0_land,
    output logic       p1_land,
    output logic [9:0] p0_land_y,
    output logic [9:0] p1_land_y,
    output logic       busy,
    output logic       done,
    output logic       overrun
);
    import plat_pkg::*;

    localparam logic [9:0] H2 = 10'(2 * HEIGHT);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0][9:0]   snap_x_q, snap_x_d, snap_y_q, snap_y_d, snap_ny_q, snap_ny_d;
    logic [1:0]        snap_drop_q, snap_drop_d;
    logic [1:0]        cand_valid_q, cand_valid_d;
    logic [1:0][9:0]   cand_py_q, cand_py_d;
    logic [1:0]        land_q, land_d;
    logic [1:0][9:0]   land_y_q, land_y_d;
    logic              overrun_q, overrun_d;

    logic              player;
    logic [PIDX_W-1:0] plat_idx;
    logic [9:0]        cur_py;
    logic              hit, skip, take;

    assign player   = (idx_q >= IDX_W'(NUM_PLAT));
    assign plat_idx = PIDX_W'(player ? (idx_q - IDX_W'(NUM_PLAT)) : idx_q);
    assign cur_py   = PLAT_Y[plat_idx];

    plat_hit_check #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_hit (
        .x      (snap_x_q[player]),
        .y      (snap_y_q[player]),
        .next_y (snap_ny_q[player]),
        .px     (PLAT_X[plat_idx]),
        .py     (cur_py),
        .pw     (PLAT_W[plat_idx]),
        .hit    (hit)
    );

`ifdef PLAT_DROP_THROUGH_EN
    // The main stage stays solid even if its table flag were ever set.
    assign skip = snap_drop_q[player] && PLAT_PASS[plat_idx] && (plat_idx != '0);
`else
    logic drop_unused;
    assign drop_unused = ^snap_drop_q;
    assign skip        = 1'b0;
`endif

    // Sweep order is ascending platform index, so a strict compare keeps the lower index on ties.
    assign take = hit && !skip && (!cand_valid_q[player] || (cur_py < cand_py_q[player]));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        snap_ny_d    = snap_ny_q;
        snap_drop_d  = snap_drop_q;
        cand_valid_d = cand_valid_q;
        cand_py_d    = cand_py_q;
        land_d       = land_q;
        land_y_d     = land_y_q;
        overrun_d    = overrun_q | (frame_tick && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d      = SCAN;
                    idx_d        = '0;
                    snap_x_d     = {p1_x, p0_x};
                    snap_y_d     = {p1_y, p0_y};
                    snap_ny_d    = {p1_next_y, p0_next_y};
                    snap_drop_d  = {p1_drop, p0_drop};
                    cand_valid_d = '0;
                    cand_py_d    = '0;
                end
            end
            SCAN: begin
                if (take) begin
                    cand_valid_d[player] = 1'b1;
                    cand_py_d[player]    = cur_py;
                end
                if (idx_q == IDX_W'(NUM_PAIRS - 1)) begin
                    state_d = DONE;
                    for (int p = 0; p < 2; p++) begin
                        land_d[p]   = cand_valid_d[p];
                        land_y_d[p] = cand_valid_d[p] ? (cand_py_d[p] - H2) : 10'd0;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            snap_ny_q    <= '0;
            snap_drop_q  <= '0;
            cand_valid_q <= '0;
            cand_py_q    <= '0;
            land_q       <= '0;
            land_y_q     <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            snap_ny_q    <= snap_ny_d;
            snap_drop_q  <= snap_drop_d;
            cand_valid_q <= cand_valid_d;
            cand_py_q    <= cand_py_d;
            land_q       <= land_d;
            land_y_q     <= land_y_d;
            overrun_q    <= overrun_d;
        end
    end

    assign p0_land   = land_q[0];
    assign p1_land   = land_q[1];
    assign p0_land_y = land_y_q[0];
    assign p1_land_y = land_y_q[1];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_plat_land_scheduler.sv
// Self-checking bench for plat_land_scheduler: vector table, scoreboard queue, corner sequences.
module tb_plat_land_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] p0_x = '0, p0_y = '0, p0_next_y = '0;
    logic [9:0] p1_x = '0, p1_y = '0, p1_next_y = '0;
    logic       p0_drop = 1'b0, p1_drop = 1'b0;
    logic       p0_land, p1_land, busy, done, overrun;
    logic [9:0] p0_land_y, p1_land_y;

    always #5 clk = ~clk;

    plat_land_scheduler dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .p0_x(p0_x), .p0_y(p0_y), .p0_next_y(p0_next_y),
        .p1_x(p1_x), .p1_y(p1_y), .p1_next_y(p1_next_y),
        .p0_drop(p0_drop), .p1_drop(p1_drop),
        .p0_land(p0_land), .p1_land(p1_land),
        .p0_land_y(p0_land_y), .p1_land_y(p1_land_y),
        .busy(busy), .done(done), .overrun(overrun)
    );

    typedef struct {
        logic [9:0] x0, y0, n0; logic d0;
        logic [9:0] x1, y1, n1; logic d1;
        logic l0; logic [9:0] ly0;
        logic l1; logic [9:0] ly1;
    } vec_t;

`ifdef PLAT_DROP_THROUGH_EN
    localparam logic [9:0] DROP_LY = 10'd340;
`else
    localparam logic [9:0] DROP_LY = 10'd155;
`endif

    localparam int NV = 8;
    vec_t vecs[NV];
    vec_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        p0_x = v.x0; p0_y = v.y0; p0_next_y = v.n0; p0_drop = v.d0;
        p1_x = v.x1; p1_y = v.y1; p1_next_y = v.n1; p1_drop = v.d1;
    endtask

    task automatic scramble();
        p0_x = 10'($urandom); p0_y = 10'($urandom); p0_next_y = 10'($urandom);
        p1_x = 10'($urandom); p1_y = 10'($urandom); p1_next_y = 10'($urandom);
        p0_drop = 1'($urandom); p1_drop = 1'($urandom);
    endtask

    task automatic chk_results(input string tag, input vec_t e);
        chk({tag, "_p0_land"},   32'(p0_land),   32'(e.l0));
        chk({tag, "_p0_land_y"}, 32'(p0_land_y), 32'(e.ly0));
        chk({tag, "_p1_land"},   32'(p1_land),   32'(e.l1));
        chk({tag, "_p1_land_y"}, 32'(p1_land_y), 32'(e.ly1));
    endtask

    // Tick in cycle T; done expected in T+7 and busy cleared in T+8.
    task automatic run_frame(input vec_t v, input string tag);
        int   cyc;
        vec_t e;
        @(negedge clk);
        apply(v);
        frame_tick = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        frame_tick = 1'b0;
        scramble();
        cyc = 1;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cycle"}, 32'(cyc), 32'd7);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk_results(tag, e);
            @(negedge clk);
            chk({tag, "_busy_end"}, 32'(busy), 32'd0);
            chk({tag, "_done_end"}, 32'(done), 32'd0);
            repeat (3) @(negedge clk);
            chk({tag, "_hold_p0_land_y"}, 32'(p0_land_y), 32'(e.ly0));
            chk({tag, "_hold_p1_land_y"}, 32'(p1_land_y), 32'(e.ly1));
        end else begin
            chk({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
        end
    endtask

    initial begin
        int   ndone, dcyc;
        vec_t e;

        vecs[0] = '{10'd430, 10'd150, 10'd160, 1'b0, 10'd900, 10'd10, 10'd20, 1'b0,
                    1'b1, 10'd155, 1'b0, 10'd0};
        vecs[1] = '{10'd374, 10'd155, 10'd155, 1'b0, 10'd900, 10'd10, 10'd20, 1'b0,
                    1'b1, 10'd155, 1'b0, 10'd0};
        vecs[2] = '{10'd900, 10'd10, 10'd20, 1'b0, 10'd200, 10'd150, 10'd350, 1'b0,
                    1'b0, 10'd0, 1'b1, 10'd155};
        vecs[3] = '{10'd900, 10'd10, 10'd20, 1'b0, 10'd200, 10'd150, 10'd350, 1'b1,
                    1'b0, 10'd0, 1'b1, DROP_LY};
        vecs[4] = '{10'd300, 10'd340, 10'd345, 1'b1, 10'd430, 10'd150, 10'd160, 1'b0,
                    1'b1, 10'd340, 1'b1, 10'd155};
        vecs[5] = '{10'd526, 10'd150, 10'd160, 1'b0, 10'd373, 10'd155, 10'd155, 1'b0,
                    1'b0, 10'd0, 1'b0, 10'd0};
        vecs[6] = '{10'd430, 10'd156, 10'd200, 1'b0, 10'd430, 10'd100, 10'd154, 1'b0,
                    1'b0, 10'd0, 1'b0, 10'd0};
        vecs[7] = '{10'd220, 10'd155, 10'd155, 1'b0, 10'd69, 10'd150, 10'd160, 1'b0,
                    1'b1, 10'd155, 1'b1, 10'd155};

        repeat (3) @(negedge clk);
        chk("rst_p0_land", 32'(p0_land), 32'd0);
        chk("rst_p0_land_y", 32'(p0_land_y), 32'd0);
        chk("rst_p1_land", 32'(p1_land), 32'd0);
        chk("rst_p1_land_y", 32'(p1_land_y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_frame(vecs[i], $sformatf("vec%0d", i));
        chk("no_overrun_yet", 32'(overrun), 32'd0);

        // Second tick three cycles into the sweep: ignored, flagged as overrun.
        @(negedge clk);
        apply(vecs[0]);
        frame_tick = 1'b1;
        exp_q.push_back(vecs[0]);
        @(negedge clk);
        frame_tick = 1'b0;
        ndone = 0;
        dcyc = 0;
        for (int c = 1; c <= 15; c++) begin
            if (done) begin
                ndone++;
                dcyc = c;
            end
            if (c == 7 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_results("ovr", e);
            end
            frame_tick = (c == 3);
            @(negedge clk);
        end
        frame_tick = 1'b0;
        chk("ovr_done_count", 32'(ndone), 32'd1);
        chk("ovr_done_cycle", 32'(dcyc), 32'd7);
        chk("ovr_flag", 32'(overrun), 32'd1);
        run_frame(vecs[2], "after_ovr");
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset asserted in T+4 of a sweep that starts from non-zero outputs.
        run_frame(vecs[4], "pre_rst");
        @(negedge clk);
        apply(vecs[0]);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_p0_land", 32'(p0_land), 32'd0);
        chk("midrst_p0_land_y", 32'(p0_land_y), 32'd0);
        chk("midrst_p1_land", 32'(p1_land), 32'd0);
        chk("midrst_p1_land_y", 32'(p1_land_y), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("midrst_quiet", 32'(ndone), 32'd0);
        run_frame(vecs[7], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
